// File: rtl/led_driver_pkg.sv
// Shared types and sizing helpers for the LED driver serial controller.
package led_driver_pkg;

    typedef enum logic [1:0] {SH_IDLE, SH_LO, SH_HI, SH_FULL} sh_state_t;
    typedef enum logic [1:0] {GS_RUN, GS_B1, GS_B2} gs_state_t;

    function automatic int frame_gs(input int chips);
        return 192 * chips;
    endfunction

    function automatic int frame_dc(input int chips);
        return 96 * chips;
    endfunction

    function automatic int beat_w(input int chips);
        return $clog2(192 * chips + 1);
    endfunction

endpackage

// File: rtl/gs_pwm_timer.sv
// Grayscale PWM timebase: GSCLK divider, edge counter and BLANK/XLAT sequencing.
module gs_pwm_timer
    import led_driver_pkg::*;
#(
    parameter int GS_BITS   = 12,
    parameter int GSCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic frame_full,
    output logic gsclk,
    output logic blank,
    output logic xlat
);

    localparam int HALF = GSCLK_DIV / 2;
    localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);
    localparam logic [GS_BITS:0] EDGES = {1'b1, {GS_BITS{1'b0}}};
    localparam logic [GS_BITS:0] EDGE_ONE = (GS_BITS + 1)'(1);

    gs_state_t state, state_n;
    logic [DW-1:0] div_cnt;
    logic [GS_BITS:0] edge_cnt;
    logic gsclk_q;
    logic half_tick;

    assign half_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= GS_B1;
        else     state <= state_n;
    end

    // The cycle ends on the falling half of the last GSCLK pulse, so GSCLK is low in GS_B1.
    always_comb begin
        state_n = state;
        case (state)
            GS_RUN: begin
                if (!enable || (half_tick && gsclk_q && edge_cnt == EDGES)) state_n = GS_B1;
            end
            GS_B1:   state_n = GS_B2;
            GS_B2:   state_n = enable ? GS_RUN : GS_B1;
            default: state_n = GS_B1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != GS_RUN || state_n != GS_RUN) begin
            div_cnt  <= '0;
            gsclk_q  <= 1'b0;
            edge_cnt <= '0;
        end else if (half_tick) begin
            div_cnt <= '0;
            gsclk_q <= ~gsclk_q;
            if (!gsclk_q) edge_cnt <= edge_cnt + EDGE_ONE;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    assign gsclk = gsclk_q;
    assign blank = (state != GS_RUN);
    assign xlat  = (state == GS_B2) && frame_full;

endmodule

// File: rtl/led_driver_ctrl.sv
// Serial shift controller for a chain of TLC5940-class drivers with PWM timebase,
// boundary-aligned frame latching and XERR monitoring.
module led_driver_ctrl
    import led_driver_pkg::*;
#(
    parameter int LANES     = 12,
    parameter int CHIPS     = 1,
    parameter int GS_BITS   = 12,
    parameter int SCLK_DIV  = 2,
    parameter int GSCLK_DIV = 2
) (
    input  logic             OSC_40,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             MODE_SEL,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    input  logic [LANES-1:0] DATA,
    output logic [LANES-1:0] DRIVER_D,
    output logic             DRIVER_SCLK,
    output logic             DRIVER_GSCLK,
    output logic             DRIVER_BLANK,
    output logic             DRIVER_XLAT,
    output logic             DRIVER_MODE,
    input  logic             DRIVER_XERR,
    input  logic             ERR_CLR,
    output logic             ERR_STICKY,
    output logic             FRAME_DONE
);

    localparam int BW = beat_w(CHIPS);
    localparam logic [BW-1:0] LEN_GS = BW'(frame_gs(CHIPS));
    localparam logic [BW-1:0] LEN_DC = BW'(frame_dc(CHIPS));
    localparam logic [BW-1:0] BEAT_ONE = BW'(1);
    localparam int HALF = SCLK_DIV / 2;
    localparam int SW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(HALF - 1);
    localparam logic [SW-1:0] SUB_ONE = SW'(1);

    sh_state_t sh_state, sh_state_n;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] frame_len;
    logic [SW-1:0] sub_cnt;
    logic [LANES-1:0] d_q;
    logic ready_q, mode_q;
    logic accept, sub_last, beat_last, latch;
    logic xerr_s1, xerr_s2, sticky_q;

    // Valid/ready: a beat transfers on a rising edge where DATA_VALID and DATA_READY are
    // both high; DATA_READY never depends on DATA_VALID, and the beat may wait indefinitely.
    assign accept    = ready_q && DATA_VALID;
    assign sub_last  = (sub_cnt == SUB_LAST);
    assign frame_len = mode_q ? LEN_DC : LEN_GS;
    assign beat_last = ((beat_cnt + BEAT_ONE) == frame_len);

    always_ff @(posedge OSC_40) begin
        if (RESET) begin
            sh_state <= SH_IDLE;
            ready_q  <= 1'b0;
        end else begin
            sh_state <= sh_state_n;
            ready_q  <= (sh_state_n == SH_IDLE);
        end
    end

    always_comb begin
        sh_state_n = sh_state;
        case (sh_state)
            SH_IDLE: if (accept)   sh_state_n = SH_LO;
            SH_LO:   if (sub_last) sh_state_n = SH_HI;
            SH_HI:   if (sub_last) sh_state_n = beat_last ? SH_FULL : SH_IDLE;
            SH_FULL: if (latch)    sh_state_n = SH_IDLE;
            default:               sh_state_n = SH_IDLE;
        endcase
    end

    // Frame length follows the mode captured on beat 0, which is held until the next frame.
    always_ff @(posedge OSC_40) begin
        if (RESET) begin
            beat_cnt <= '0;
            sub_cnt  <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
        end else begin
            if (accept) begin
                d_q <= DATA;
                if (beat_cnt == '0) mode_q <= MODE_SEL;
            end
            if (sh_state == SH_LO || sh_state == SH_HI) sub_cnt <= sub_last ? '0 : sub_cnt + SUB_ONE;
            else                                        sub_cnt <= '0;
            if (sh_state == SH_HI && sub_last)          beat_cnt <= beat_cnt + BEAT_ONE;
            else if (sh_state == SH_FULL && latch)      beat_cnt <= '0;
        end
    end

    gs_pwm_timer #(
        .GS_BITS   (GS_BITS),
        .GSCLK_DIV (GSCLK_DIV)
    ) u_pwm (
        .clk        (OSC_40),
        .rst        (RESET),
        .enable     (ENABLE),
        .frame_full (sh_state == SH_FULL),
        .gsclk      (DRIVER_GSCLK),
        .blank      (DRIVER_BLANK),
        .xlat       (latch)
    );

    // XERR is asynchronous; only errors seen while the outputs are active count.
    always_ff @(posedge OSC_40) begin
        if (RESET) begin
            xerr_s1  <= 1'b1;
            xerr_s2  <= 1'b1;
            sticky_q <= 1'b0;
        end else begin
            xerr_s1 <= DRIVER_XERR;
            xerr_s2 <= xerr_s1;
            if (!xerr_s2 && !DRIVER_BLANK) sticky_q <= 1'b1;
            else if (ERR_CLR)              sticky_q <= 1'b0;
        end
    end

    assign DATA_READY  = ready_q;
    assign DRIVER_D    = d_q;
    assign DRIVER_SCLK = (sh_state == SH_HI);
    assign DRIVER_MODE = mode_q;
    assign DRIVER_XLAT = latch;
    assign FRAME_DONE  = latch;
    assign ERR_STICKY  = sticky_q;

endmodule

// File: tb/tb_led_driver_ctrl.sv
// Self-checking bench for led_driver_ctrl: PWM timebase, frame streaming, latching and XERR.
module tb_led_driver_ctrl;

    localparam int LANES     = 2;
    localparam int CHIPS     = 1;
    localparam int GS_BITS   = 4;
    localparam int SCLK_DIV  = 2;
    localparam int GSCLK_DIV = 2;
    localparam int PERIOD    = (1 << GS_BITS) * GSCLK_DIV + 2;
    localparam int BEAT_PER  = SCLK_DIV + 1;

    logic OSC_40 = 1'b0;
    logic RESET, ENABLE, MODE_SEL, DATA_VALID, DRIVER_XERR, ERR_CLR;
    logic [LANES-1:0] DATA;
    logic DATA_READY, DRIVER_SCLK, DRIVER_GSCLK, DRIVER_BLANK, DRIVER_XLAT;
    logic DRIVER_MODE, ERR_STICKY, FRAME_DONE;
    logic [LANES-1:0] DRIVER_D;

    logic [LANES-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 OSC_40 = ~OSC_40;

    led_driver_ctrl #(
        .LANES(LANES), .CHIPS(CHIPS), .GS_BITS(GS_BITS),
        .SCLK_DIV(SCLK_DIV), .GSCLK_DIV(GSCLK_DIV)
    ) dut (
        .OSC_40(OSC_40), .RESET(RESET), .ENABLE(ENABLE), .MODE_SEL(MODE_SEL),
        .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .DATA(DATA),
        .DRIVER_D(DRIVER_D), .DRIVER_SCLK(DRIVER_SCLK), .DRIVER_GSCLK(DRIVER_GSCLK),
        .DRIVER_BLANK(DRIVER_BLANK), .DRIVER_XLAT(DRIVER_XLAT), .DRIVER_MODE(DRIVER_MODE),
        .DRIVER_XERR(DRIVER_XERR), .ERR_CLR(ERR_CLR), .ERR_STICKY(ERR_STICKY),
        .FRAME_DONE(FRAME_DONE)
    );

    // {READY, D, SCLK, GSCLK, BLANK, XLAT, MODE, STICKY, DONE}
    function automatic logic [LANES+7:0] out_vec();
        return {DATA_READY, DRIVER_D, DRIVER_SCLK, DRIVER_GSCLK, DRIVER_BLANK,
                DRIVER_XLAT, DRIVER_MODE, ERR_STICKY, FRAME_DONE};
    endfunction

    task automatic check_reset_outputs(input string name);
        logic [LANES+7:0] exp_v;
        exp_v = '0;
        exp_v[4] = 1'b1;
        checks++;
        if (out_vec() !== exp_v) begin
            errors++;
            $display("FAIL %s: outputs=%b expected=%b", name, out_vec(), exp_v);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge OSC_40);
        check_reset_outputs("reset_values");
        RESET = 1'b0;
    endtask

    // Starts on the negedge where RESET was released: that cycle is GS_B1.
    task automatic test_pwm();
        int ph;
        logic exp_blank, exp_gsclk;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            ph = c % PERIOD;
            exp_blank = (ph < 2);
            exp_gsclk = (ph >= 2) && (((ph - 2) % 2) == 1);
            checks += 3;
            if (DRIVER_BLANK !== exp_blank) begin
                errors++;
                $display("FAIL pwm_blank c=%0d: got %b expected %b", c, DRIVER_BLANK, exp_blank);
            end
            if (DRIVER_GSCLK !== exp_gsclk) begin
                errors++;
                $display("FAIL pwm_gsclk c=%0d: got %b expected %b", c, DRIVER_GSCLK, exp_gsclk);
            end
            if (DRIVER_XLAT !== 1'b0) begin
                errors++;
                $display("FAIL pwm_no_xlat c=%0d: got %b expected 0", c, DRIVER_XLAT);
            end
            @(negedge OSC_40);
        end
    endtask

    task automatic run_frame(input string name, input int n, input logic mode,
                             input bit stall, input bit disabled);
        int edges = 0, cyc = 0, last_edge = 0, xlat_cnt = 0, xlat_cyc = 0, full_blank = 0;
        int period_bad = 0, mode_bad = 0, ready_bad = 0, xlat_bad = 0, gs_bad = 0;
        int budget;
        bit drv_to = 0;
        bit done = 0;
        logic prev_sclk, prev_blank;
        logic [LANES-1:0] exp_d;
        budget = n * (BEAT_PER + 6) + 4 * PERIOD;
        prev_sclk = DRIVER_SCLK;
        prev_blank = DRIVER_BLANK;
        fork
            begin : driver
                logic [LANES-1:0] bits;
                int t;
                for (int i = 0; i < n && !drv_to; i++) begin
                    if (stall && $urandom_range(0, 3) == 0) begin
                        DATA_VALID = 1'b0;
                        repeat ($urandom_range(1, 4)) @(negedge OSC_40);
                    end
                    bits = LANES'($urandom_range(0, (1 << LANES) - 1));
                    DATA = bits;
                    DATA_VALID = 1'b1;
                    MODE_SEL = (i == 0) ? mode : ~mode;
                    t = 0;
                    while (!DATA_READY && t < 200) begin
                        @(negedge OSC_40);
                        t++;
                    end
                    if (t >= 200) drv_to = 1;
                    else begin
                        exp_q.push_back(bits);
                        @(negedge OSC_40);
                    end
                end
                DATA_VALID = 1'b0;
                MODE_SEL = 1'b0;
            end
            begin : monitor
                while (!done) begin
                    @(negedge OSC_40);
                    cyc++;
                    if (DRIVER_SCLK && !prev_sclk) begin
                        if (!stall && edges > 0 && cyc - last_edge != BEAT_PER) period_bad++;
                        last_edge = cyc;
                        edges++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL %s_d[%0d]: SCLK edge with no beat outstanding", name, edges);
                        end else begin
                            exp_d = exp_q.pop_front();
                            if (DRIVER_D !== exp_d) begin
                                errors++;
                                $display("FAIL %s_d[%0d]: got %b expected %b", name, edges, DRIVER_D, exp_d);
                            end
                        end
                        if (DRIVER_MODE !== mode) mode_bad++;
                    end
                    if (FRAME_DONE !== DRIVER_XLAT) xlat_bad++;
                    if (edges == n && xlat_cnt == 0 && !DRIVER_SCLK) begin
                        if (DATA_READY) ready_bad++;
                        if (!DRIVER_XLAT && (disabled || DRIVER_BLANK)) full_blank++;
                    end
                    if (DRIVER_XLAT) begin
                        xlat_cnt++;
                        xlat_cyc = cyc;
                        if (!DRIVER_BLANK || !prev_blank || edges != n || full_blank > 1) xlat_bad++;
                        if (DRIVER_MODE !== mode) mode_bad++;
                    end
                    if (disabled && (DRIVER_GSCLK || !DRIVER_BLANK)) gs_bad++;
                    prev_sclk = DRIVER_SCLK;
                    prev_blank = DRIVER_BLANK;
                    if (xlat_cnt > 0 && cyc - xlat_cyc >= 2 * PERIOD) done = 1;
                    if (cyc > budget) done = 1;
                end
            end
        join
        checks += 7;
        if (drv_to) begin
            errors++;
            $display("FAIL %s_ready_timeout: DATA_READY stayed low, got %0d beats of %0d", name, edges, n);
        end
        if (edges != n) begin
            errors++;
            $display("FAIL %s_edges: got %0d expected %0d", name, edges, n);
        end
        if (xlat_cnt != 1) begin
            errors++;
            $display("FAIL %s_xlat_count: got %0d expected 1", name, xlat_cnt);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d beats unshifted expected 0", name, exp_q.size());
        end
        if (mode_bad != 0) begin
            errors++;
            $display("FAIL %s_mode: got %0d bad samples expected 0 (mode %b)", name, mode_bad, mode);
        end
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL %s_ready_full: got %0d cycles ready while full expected 0", name, ready_bad);
        end
        if (xlat_bad != 0) begin
            errors++;
            $display("FAIL %s_xlat_timing: got %0d bad latch cycles expected 0", name, xlat_bad);
        end
        if (!stall) begin
            checks++;
            if (period_bad != 0) begin
                errors++;
                $display("FAIL %s_sclk_period: got %0d bad periods expected 0", name, period_bad);
            end
        end
        if (disabled) begin
            checks++;
            if (gs_bad != 0) begin
                errors++;
                $display("FAIL %s_disabled_pwm: got %0d active cycles expected 0", name, gs_bad);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_gs_frame();
        run_frame("gs_frame", 192 * CHIPS, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dc_frame();
        run_frame("dc_frame", 96 * CHIPS, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_disabled_latch();
        int t = 0;
        while (DRIVER_BLANK && t < 2 * PERIOD) begin
            @(negedge OSC_40);
            t++;
        end
        ENABLE = 1'b0;
        @(negedge OSC_40);
        checks++;
        if (!(DRIVER_BLANK === 1'b1 && DRIVER_GSCLK === 1'b0)) begin
            errors++;
            $display("FAIL enable_fall: got blank=%b gsclk=%b expected blank=1 gsclk=0",
                     DRIVER_BLANK, DRIVER_GSCLK);
        end
        run_frame("disabled_frame", 96 * CHIPS, 1'b1, 1'b0, 1'b1);
        ENABLE = 1'b1;
    endtask

    task automatic expect_sticky(input string name, input logic exp_v);
        checks++;
        if (ERR_STICKY !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, ERR_STICKY, exp_v);
        end
    endtask

    task automatic test_xerr();
        int t = 0;
        while (!DRIVER_BLANK && t < 2 * PERIOD) begin @(negedge OSC_40); t++; end
        while (DRIVER_BLANK && t < 2 * PERIOD) begin @(negedge OSC_40); t++; end
        checks++;
        if (t >= 2 * PERIOD) begin
            errors++;
            $display("FAIL xerr_sync: got no BLANK fall within %0d cycles expected one", 2 * PERIOD);
        end
        // Now in the first GS_RUN cycle of a period.
        DRIVER_XERR = 1'b0;
        repeat (2) @(negedge OSC_40);
        expect_sticky("xerr_sync_delay", 1'b0);
        @(negedge OSC_40);
        DRIVER_XERR = 1'b1;
        expect_sticky("xerr_set", 1'b1);
        @(negedge OSC_40);
        ERR_CLR = 1'b1;
        @(negedge OSC_40);
        ERR_CLR = 1'b0;
        expect_sticky("clr_vs_set", 1'b1);
        @(negedge OSC_40);
        ERR_CLR = 1'b1;
        @(negedge OSC_40);
        ERR_CLR = 1'b0;
        expect_sticky("err_clr", 1'b0);
        t = 0;
        while (!DRIVER_BLANK && t < 2 * PERIOD) begin @(negedge OSC_40); t++; end
        repeat (PERIOD - 2) @(negedge OSC_40);
        DRIVER_XERR = 1'b0;
        repeat (2) @(negedge OSC_40);
        DRIVER_XERR = 1'b1;
        repeat (5) @(negedge OSC_40);
        expect_sticky("xerr_in_blank", 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int t;
        DATA = 2'b10;
        MODE_SEL = 1'b1;
        DATA_VALID = 1'b1;
        t = 0;
        while (!DATA_READY && t < 200) begin @(negedge OSC_40); t++; end
        @(negedge OSC_40);
        DATA_VALID = 1'b0;
        MODE_SEL = 1'b0;
        checks++;
        if (!(DRIVER_D === 2'b10 && DRIVER_SCLK === 1'b0)) begin
            errors++;
            $display("FAIL accept_to_d: got d=%b sclk=%b expected d=10 sclk=0", DRIVER_D, DRIVER_SCLK);
        end
        @(negedge OSC_40);
        checks++;
        if (!(DRIVER_SCLK === 1'b1 && DRIVER_MODE === 1'b1)) begin
            errors++;
            $display("FAIL accept_to_sclk: got sclk=%b mode=%b expected sclk=1 mode=1",
                     DRIVER_SCLK, DRIVER_MODE);
        end
        for (int i = 1; i < 50; i++) begin
            DATA = LANES'($urandom_range(0, (1 << LANES) - 1));
            DATA_VALID = 1'b1;
            t = 0;
            while (!DATA_READY && t < 200) begin @(negedge OSC_40); t++; end
            @(negedge OSC_40);
        end
        DATA_VALID = 1'b0;
        RESET = 1'b1;
        @(negedge OSC_40);
        check_reset_outputs("reset_mid_frame");
        RESET = 1'b0;
        run_frame("post_reset_frame", 192 * CHIPS, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        ENABLE = 1'b1;
        MODE_SEL = 1'b0;
        DATA_VALID = 1'b0;
        DATA = '0;
        DRIVER_XERR = 1'b1;
        ERR_CLR = 1'b0;
        test_reset();
        test_pwm();
        test_gs_frame();
        test_dc_frame();
        test_disabled_latch();
        test_xerr();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_driver_ctrl.md
# led_driver_ctrl

Parametrised serial controller for the tile's chain of TLC5940-class constant-current LED drivers. It accepts a per-lane bit stream from the frame fetcher and shifts it out on the driver data lanes with `DRIVER_SCLK`. It runs the grayscale PWM timebase on `DRIVER_GSCLK`/`DRIVER_BLANK` and latches each completed frame with `DRIVER_XLAT` only at a PWM cycle boundary. It generalises the fixed 6+6-lane tie-off in the tile top to N lanes, multi-chip chains, grayscale and dot-correction modes, and XERR monitoring.

## Interface
Parameters:
- `LANES`, 12: number of parallel data lanes. Top maps `[5:0]` to `DRIVER_L` and `[11:6]` to `DRIVER_R`.
- `CHIPS`, 1: drivers daisy-chained per lane.
- `GS_BITS`, 12: grayscale resolution. The PWM cycle is 2^GS_BITS GSCLK edges.
- `SCLK_DIV`, 2: SCLK period in clocks. Even, ≥2.
- `GSCLK_DIV`, 2: GSCLK period in clocks. Even, ≥2.

Ports:
- `OSC_40` in 1: the only clock. All logic is on its rising edge.
- `RESET` in 1: synchronous reset, active-high.
- `ENABLE` in 1: 0 forces blanking and stops the PWM timebase.
- `MODE_SEL` in 1: frame type, sampled on the first beat of a frame. 0 = grayscale, 1 = dot-correction.
- `DATA_VALID` in 1: bit-beat valid.
- `DATA_READY` out 1: block accepts a beat.
- `DATA` in LANES: one bit per lane per beat, chain-MSB first.
- `DRIVER_D` out LANES: serial data to the drivers.
- `DRIVER_SCLK` out 1: shift clock.
- `DRIVER_GSCLK` out 1: grayscale clock.
- `DRIVER_BLANK` out 1: driver blank.
- `DRIVER_XLAT` out 1: driver latch.
- `DRIVER_MODE` out 1: driver mode.
- `DRIVER_XERR` in 1: driver error flag, open-drain, active-low, asynchronous.
- `ERR_CLR` in 1: clears `ERR_STICKY`.
- `ERR_STICKY` out 1: latched driver error.
- `FRAME_DONE` out 1: one-cycle pulse, coincident with `DRIVER_XLAT`.

## Operation
- Frame length: `FRAME_GS` = 192·CHIPS beats; `FRAME_DC` = 96·CHIPS beats. The length is chosen by `MODE_SEL` captured at beat 0.
- Shift FSM states: SH_IDLE, SH_LO, SH_HI, SH_FULL.
  - SH_IDLE: `DATA_READY`=1. On accept, register `DATA` to `DRIVER_D`. At beat 0, also register `MODE_SEL` to `DRIVER_MODE`. Go to SH_LO.
  - SH_LO: SCLK=0 for SCLK_DIV/2 cycles, then go to SH_HI.
  - SH_HI: SCLK=1 for SCLK_DIV/2 cycles. Then increment the beat count. If count = frame length, go to SH_FULL; otherwise go to SH_IDLE.
  - SH_FULL: `DATA_READY`=0. Hold until the latch; then go to SH_IDLE with the beat count cleared.
- `DRIVER_D` and `DRIVER_MODE` are stable throughout SH_LO/SH_HI. `DRIVER_MODE` is stable from beat 0 through the latch.
- PWM FSM states: GS_RUN, GS_B1, GS_B2.
  - GS_RUN: BLANK=0. GSCLK toggles every GSCLK_DIV/2 cycles, starting low. After 2^GS_BITS rising edges, go to GS_B1 with GSCLK=0.
  - GS_B1: BLANK=1 for one cycle.
  - GS_B2: BLANK=1 for one cycle. If the shift FSM is in SH_FULL, pulse `DRIVER_XLAT` and `FRAME_DONE`, and release the shift FSM. Clear the edge counter and go to GS_RUN.
- `ENABLE`=0: the PWM FSM cycles GS_B1→GS_B2→GS_B1 with BLANK=1, GSCLK=0 and the counter cleared. Shifting continues, and a full frame latches at the next GS_B2.
- XERR: passes through a two-flop synchroniser. `ERR_STICKY` sets when the synchronised XERR=0 and BLANK=0. `ERR_CLR` clears it; set wins if both occur in the same cycle.
- A `DATA_VALID` deassertion mid-frame only stalls the frame; nothing is lost.

## Timing
- Reset values: `DRIVER_BLANK`=1, all other outputs 0. State after reset is SH_IDLE and GS_B1. A partial frame and the GS count are discarded.
- Input-to-output latency: one clock from accept to `DRIVER_D`. SCLK rises SCLK_DIV/2+1 cycles after accept.
- Minimum beat period: SCLK_DIV+1 cycles.
- PWM period: 2^GS_BITS·GSCLK_DIV + 2 cycles. BLANK is high for exactly 2 cycles per period.
- Edge cases:
  - A frame completing in the same cycle the FSM enters GS_B2 latches in that GS_B2.
  - XLAT is never asserted outside GS_B2, and never while BLANK=0.
  - `ENABLE` falling mid-GS_RUN goes to GS_B1 on the next cycle.

## Structure
- Package `led_driver_pkg` holds:
  - `FRAME_GS`/`FRAME_DC` functions of CHIPS;
  - shift and PWM state enums;
  - the beat-counter width `$clog2(192·CHIPS+1)`.
- One sub-module, `gs_pwm_timer`, contains the PWM FSM, the GSCLK divider, the edge counter, and the BLANK/XLAT sequencing. The shift FSM, the XERR synchroniser and the error flag stay in the top module.

## Test plan
Test parameters: LANES=2, CHIPS=1, GS_BITS=4, SCLK_DIV=2, GSCLK_DIV=2, which gives a 34-cycle PWM period.
- After reset with ENABLE=1: BLANK=1 for 2 cycles, then 16 GSCLK pulses. BLANK high exactly 2 of every 34 cycles. XLAT never pulses.
- Stream 192 beats, MODE_SEL=0, continuous valid: 192 SCLK rising edges at a 3-cycle period. `DRIVER_D` matches the input order. Exactly one XLAT/FRAME_DONE, in the next GS_B2. `DRIVER_MODE`=0. READY=0 from full until the latch.
- DC frame of 96 beats, MODE_SEL=1: `DRIVER_MODE`=1 from beat 0. Latch after beat 96.
- Frame completes while ENABLE=0: latch occurs within 2 cycles. GSCLK stays 0.
- XERR driven low for 3 cycles during GS_RUN: `ERR_STICKY`=1 about 3 cycles later. XERR low only during BLANK: no set. ERR_CLR and a new error in the same cycle: stays 1.
- RESET asserted at beat 50: outputs return to their reset values. The next frame needs a full 192 beats before it latches.
